// File: rtl/hart_defs_pkg.sv
// Shared hart-level definitions: PC/fetch bundles and the fetch credit limit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hart_defs;

    localparam int XLEN         = 32;
    localparam int MAX_INFLIGHT = 2;

    // Upstream PC pipeline register contents.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
    } pc_t;

    // Fetched instruction handed to decode.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with registered storage and a synchronous clear.
// Latency: pushed data is visible at the head one cycle after the push edge.
// Backpressure: none internal; a push into a full FIFO without a same-cycle pop is ignored.
//
// Ports:
//   clock, reset         - clock and asynchronous active-high reset
//   clear                - drops all entries at the next edge (push/pop ignored that cycle)
//   push, push_data      - write one entry
//   pop                  - retire the head entry (ignored when empty)
//   head_data            - current head entry (stale when count == 0)
//   count                - number of valid entries
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Wrap explicitly so non-power-of-two depths stay in range.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop    = pop && (count != '0);
    // A full FIFO can still accept a push when the head leaves in the same cycle.
    assign do_push   = push && ((count != CW'(DEPTH)) || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: issues imem reads for upstream PCs and pairs in-order responses with their PCs.
// Latency: inst_out valid one cycle after the memory response; request issue is combinational.
// Backpressure: credit limit on in-flight + buffered entries; stall_out on stall_in, !imem_req_ready or no credit.
//
// Ports:
//   clock, reset                     - clock and asynchronous active-high reset
//   pc_in                            - upstream PC {valid, pc}
//   stall_out                        - hold request to the upstream PC stage
//   stall_in                         - decode cannot take inst_out this cycle
//   flush_in                         - redirect: drop buffered work and discard outstanding responses
//   imem_req_valid/ready/addr        - instruction memory read request channel
//   imem_resp_valid/data             - in-order read responses, no backpressure
//   inst_out                         - fetched {valid, pc, inst} to decode
module fetch_stage
    import hart_defs::pc_t;
    import hart_defs::fetch_t;
#(
    parameter int MAX_INFLIGHT = hart_defs::MAX_INFLIGHT,
    // Must match hart_defs::XLEN, which sizes pc_t and fetch_t.
    parameter int XLEN         = hart_defs::XLEN
) (
    input  logic            clock,
    input  logic            reset,
    input  pc_t             pc_in,
    output logic            stall_out,
    input  logic            stall_in,
    input  logic            flush_in,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output fetch_t          inst_out
);

    localparam int            CW       = $clog2(MAX_INFLIGHT + 1);
    localparam int            FW       = $bits(fetch_t);
    localparam logic [CW:0]   CRED_MAX = (CW + 1)'(MAX_INFLIGHT);

    logic [CW-1:0]   inflight;   // issued, response not yet returned (includes discarded ones)
    logic [CW-1:0]   discard;    // responses still owed to requests issued before a flush
    logic [CW-1:0]   bufcnt;
    logic [CW-1:0]   pendcnt;
    logic [CW:0]     credits;
    logic            issue;
    logic            resp_ok;
    logic            resp_keep;
    logic            buf_pop;
    logic [XLEN-1:0] pend_pc;
    fetch_t          buf_wr;
    logic [FW-1:0]   buf_head;

    assign credits = {1'b0, inflight} + {1'b0, bufcnt};

    assign stall_out      = stall_in || !imem_req_ready || (credits == CRED_MAX);
    assign imem_req_valid = pc_in.valid && !flush_in && (credits < CRED_MAX);
    assign imem_req_addr  = pc_in.pc;
    assign issue          = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_ok   = imem_resp_valid && (inflight != '0);
    // Responses owed to pre-flush requests, or arriving with a flush, never reach decode.
    assign resp_keep = resp_ok && (discard == '0) && !flush_in;
    assign buf_pop   = (bufcnt != '0) && !stall_in;

    assign buf_wr = '{valid: 1'b1, pc: pend_pc, inst: imem_resp_data};

    // Storage is not wiped on flush, so mask the head while empty.
    assign inst_out = (bufcnt != '0) ? fetch_t'(buf_head) : '0;

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_INFLIGHT)
    ) u_pend_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (flush_in),
        .push      (issue),
        .push_data (pc_in.pc),
        .pop       (resp_keep),
        .head_data (pend_pc),
        .count     (pendcnt)
    );

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (MAX_INFLIGHT)
    ) u_out_buf (
        .clock     (clock),
        .reset     (reset),
        .clear     (flush_in),
        .push      (resp_keep),
        .push_data (buf_wr),
        .pop       (buf_pop),
        .head_data (buf_head),
        .count     (bufcnt)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight + CW'(issue) - CW'(resp_ok);
            if (flush_in) begin
                // issue is blocked during flush, so only a same-cycle response reduces the debt.
                discard <= inflight - CW'(resp_ok);
            end else if (resp_ok && (discard != '0)) begin
                discard <= discard - CW'(1);
            end
        end
    end

    a_resp_without_request: assert property (
        @(posedge clock) disable iff (reset) imem_resp_valid |-> (inflight != '0)
    ) else $error("fetch_stage: imem response with no request in flight");

    a_pending_pc_present: assert property (
        @(posedge clock) disable iff (reset) resp_keep |-> (pendcnt != '0)
    ) else $error("fetch_stage: kept response with empty pending-PC queue");

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
module tb_fetch_stage;
    import hart_defs::*;

    logic              clock = 1'b0;
    logic              reset;
    pc_t               pc_in;
    logic              stall_out;
    logic              stall_in;
    logic              flush_in;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_resp_valid;
    logic [XLEN-1:0]   imem_resp_data;
    fetch_t            inst_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    fetch_stage #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .XLEN         (XLEN)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .pc_in           (pc_in),
        .stall_out       (stall_out),
        .stall_in        (stall_in),
        .flush_in        (flush_in),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_out        (inst_out)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Outstanding requests: a queue of PCs still owed a response, plus a
    // count of responses to throw away after a flush. Decode sees a queue
    // of delivered instructions.
    int          m_owed    = 0;
    int          m_discard = 0;
    logic [XLEN-1:0] m_pend[$];
    fetch_t      m_out[$];

    function automatic int m_credits();
        return m_owed + m_out.size();
    endfunction

    // Inputs are stable from posedge+1 through the next posedge, so the
    // negedge sees exactly what the DUT will sample at the coming edge.
    always @(negedge clock) begin
        logic   exp_rv;
        logic   exp_st;
        fetch_t exp_io;
        logic   take;
        logic   got;
        logic   drain;
        fetch_t item;
        if (reset) begin
            m_owed = 0;
            m_discard = 0;
            m_pend.delete();
            m_out.delete();
        end
        exp_rv = pc_in.valid && !flush_in && (m_credits() < MAX_INFLIGHT);
        exp_st = stall_in || !imem_req_ready || (m_credits() == MAX_INFLIGHT);
        exp_io = (m_out.size() > 0) ? m_out[0] : '0;
        check("model_req_valid", imem_req_valid, exp_rv);
        check("model_req_addr", imem_req_addr, pc_in.pc);
        check("model_stall_out", stall_out, exp_st);
        check("model_inst_out", inst_out, exp_io);
        if (!reset) begin
            take  = exp_rv && imem_req_ready;
            got   = imem_resp_valid && (m_owed > 0);
            drain = (m_out.size() > 0) && !stall_in;
            if (flush_in) begin
                m_discard = m_owed - (got ? 1 : 0);
                m_pend.delete();
                m_out.delete();
            end else begin
                if (drain) void'(m_out.pop_front());
                if (got) begin
                    if (m_discard > 0) begin
                        m_discard--;
                    end else begin
                        item.valid = 1'b1;
                        item.pc    = m_pend.pop_front();
                        item.inst  = imem_resp_data;
                        m_out.push_back(item);
                    end
                end
                if (take) m_pend.push_back(pc_in.pc);
            end
            m_owed = m_owed + (take ? 1 : 0) - (got ? 1 : 0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_pc(input logic v, input logic [XLEN-1:0] pc);
        pc_in.valid = v;
        pc_in.pc    = pc;
    endtask

    task automatic set_resp(input logic v, input logic [XLEN-1:0] d);
        imem_resp_valid = v;
        imem_resp_data  = d;
    endtask

    initial begin
        reset = 1'b1;
        set_pc(1'b0, '0);
        stall_in = 1'b0;
        flush_in = 1'b0;
        imem_req_ready = 1'b1;
        set_resp(1'b0, '0);
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        check("reset_inst_out", inst_out, '0);
        check("reset_stall_out", stall_out, 1'b0);
        check("reset_req_valid", imem_req_valid, 1'b0);

        // Single fetch, response two cycles after issue.
        set_pc(1'b1, 32'h100);
        #1;
        check("s1_req_valid", imem_req_valid, 1'b1);
        check("s1_req_addr", imem_req_addr, 32'h100);
        cyc();
        set_pc(1'b0, '0);
        cyc();
        set_resp(1'b1, 32'h13);
        #1;
        check("s1_not_yet", inst_out.valid, 1'b0);
        cyc();
        set_resp(1'b0, '0);
        #1;
        check("s1_inst_out", inst_out, {1'b1, 32'h100, 32'h13});
        cyc();
        check("s1_popped", inst_out.valid, 1'b0);

        // Credit limit: third request held off.
        set_pc(1'b1, 32'h100);
        cyc();
        set_pc(1'b1, 32'h104);
        #1;
        check("s2_second_issue", imem_req_valid, 1'b1);
        check("s2_second_nostall", stall_out, 1'b0);
        cyc();
        set_pc(1'b1, 32'h108);
        #1;
        check("s2_third_held", imem_req_valid, 1'b0);
        check("s2_stall_full", stall_out, 1'b1);
        cyc();
        check("s2_still_held", imem_req_valid, 1'b0);
        set_resp(1'b1, 32'hA0);
        cyc();
        set_resp(1'b1, 32'hA4);
        #1;
        check("s2_first_out", inst_out, {1'b1, 32'h100, 32'hA0});
        check("s2_credit_still_full", imem_req_valid, 1'b0);
        cyc();
        set_resp(1'b0, '0);
        #1;
        check("s2_second_out", inst_out, {1'b1, 32'h104, 32'hA4});
        check("s2_third_issue", imem_req_valid, 1'b1);
        cyc();
        set_pc(1'b0, '0);
        set_resp(1'b1, 32'hA8);
        cyc();
        set_resp(1'b0, '0);
        #1;
        check("s2_third_out", inst_out, {1'b1, 32'h108, 32'hA8});
        cyc();

        // Flush with two in flight: both responses dropped.
        set_pc(1'b1, 32'h300);
        cyc();
        set_pc(1'b1, 32'h304);
        cyc();
        set_pc(1'b0, '0);
        flush_in = 1'b1;
        cyc();
        flush_in = 1'b0;
        #1;
        check("s3_after_flush", inst_out.valid, 1'b0);
        set_resp(1'b1, 32'hAA);
        cyc();
        set_resp(1'b1, 32'hBB);
        cyc();
        set_resp(1'b0, '0);
        #1;
        check("s3_dropped", inst_out.valid, 1'b0);
        set_pc(1'b1, 32'h200);
        #1;
        check("s3_new_issue", imem_req_valid, 1'b1);
        cyc();
        set_pc(1'b0, '0);
        set_resp(1'b1, 32'hCC);
        cyc();
        set_resp(1'b0, '0);
        #1;
        check("s3_inst_out", inst_out, {1'b1, 32'h200, 32'hCC});
        cyc();

        // Decode stalled for 5 cycles while two responses land.
        stall_in = 1'b1;
        set_pc(1'b1, 32'h400);
        cyc();
        set_pc(1'b1, 32'h404);
        cyc();
        set_pc(1'b0, '0);
        set_resp(1'b1, 32'h11);
        cyc();
        set_resp(1'b1, 32'h22);
        cyc();
        set_resp(1'b0, '0);
        #1;
        check("s4_head_held", inst_out, {1'b1, 32'h400, 32'h11});
        check("s4_stall_out", stall_out, 1'b1);
        cyc();
        check("s4_head_still", inst_out, {1'b1, 32'h400, 32'h11});
        stall_in = 1'b0;
        cyc();
        check("s4_second", inst_out, {1'b1, 32'h404, 32'h22});
        cyc();
        check("s4_drained", inst_out.valid, 1'b0);

        // Flush coinciding with a response: exactly one more is dropped.
        set_pc(1'b1, 32'h500);
        cyc();
        set_pc(1'b1, 32'h504);
        cyc();
        set_pc(1'b0, '0);
        flush_in = 1'b1;
        set_resp(1'b1, 32'hD0);
        cyc();
        flush_in = 1'b0;
        set_resp(1'b0, '0);
        set_pc(1'b1, 32'h600);
        #1;
        check("s5_flush_clear", inst_out.valid, 1'b0);
        check("s5_issue_after", imem_req_valid, 1'b1);
        cyc();
        set_pc(1'b0, '0);
        set_resp(1'b1, 32'hD4);
        cyc();
        check("s5_d4_dropped", inst_out.valid, 1'b0);
        set_resp(1'b1, 32'hE0);
        cyc();
        set_resp(1'b0, '0);
        #1;
        check("s5_inst_out", inst_out, {1'b1, 32'h600, 32'hE0});
        cyc();

        // Asynchronous reset with two requests outstanding.
        set_pc(1'b1, 32'h700);
        cyc();
        set_pc(1'b1, 32'h704);
        cyc();
        set_pc(1'b1, 32'h708);
        #1;
        check("s6_full_stall", stall_out, 1'b1);
        check("s6_full_noreq", imem_req_valid, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("s6_reset_valid", inst_out.valid, 1'b0);
        check("s6_reset_stall", stall_out, 1'b0);
        check("s6_reset_credits", imem_req_valid, 1'b1);
        cyc();
        set_pc(1'b0, '0);
        cyc();
        reset = 1'b0;
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
